// File: rtl/carfield_mbox_responder.sv
// carfield_mbox_responder
// Register-bus responder for the inter-domain mailbox window. It holds
// NumMbox mailboxes of 0x20 bytes each. Every mailbox has two data words,
// a doorbell, an acknowledge path and per-direction interrupt enables.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   req_valid_i  request valid, held until rsp_ready_o
//   req_write_i  1 = write, 0 = read
//   req_addr_i   byte address (MboxBase is subtracted internally)
//   req_wdata_i  write data
//   req_wstrb_i  byte strobes
//   rsp_ready_o  one-cycle response pulse, one cycle after acceptance
//   rsp_rdata_o  read data, valid with rsp_ready_o
//   rsp_error_o  decode error, valid with rsp_ready_o
//   rcv_irq_o    per-mailbox receiver interrupt (pend & rcv_en)
//   snd_irq_o    per-mailbox sender interrupt (ackp & snd_en)
//
// Register map per mailbox (offset = reg * 4)
//   0 DATA0     RW, byte strobes honoured
//   1 DATA1     RW, byte strobes honoured
//   2 DOORBELL  read {31'b0, pend}; writing bit0=1 sets pend, and sets ovf if pend was already set
//   3 ACK       read 0; writing bit0=1 clears pend and sets ackp
//   4 IRQ_EN    bit0 rcv_en, bit1 snd_en
//   5 ACK_STAT  read {30'b0, ovf, ackp}; write-1-to-clear
//
// FSM
//   state | meaning
//   IDLE  | waiting for req_valid_i; the access is performed at the accepting edge
//   RESP  | rsp_ready_o high for one cycle with the latched rdata/error
module carfield_mbox_responder #(
  parameter int unsigned          NumMbox   = 4,
  parameter int unsigned          AddrWidth = 48,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] MboxBase  = 'h4000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_ready_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NumMbox-1:0]   rcv_irq_o,
  output logic [NumMbox-1:0]   snd_irq_o
);

  localparam int unsigned          IdxW    = (NumMbox > 1) ? $clog2(NumMbox) : 1;
  localparam logic [AddrWidth-1:0] WinSize = AddrWidth'(NumMbox * 32);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [NumMbox-1:0][DataWidth-1:0] data0_q, data0_d;
  logic [NumMbox-1:0][DataWidth-1:0] data1_q, data1_d;
  logic [NumMbox-1:0]                pend_q, pend_d;
  logic [NumMbox-1:0]                ackp_q, ackp_d;
  logic [NumMbox-1:0]                ovf_q, ovf_d;
  logic [NumMbox-1:0]                rcv_en_q, rcv_en_d;
  logic [NumMbox-1:0]                snd_en_q, snd_en_d;
  logic [DataWidth-1:0]              rdata_q, rdata_d;
  logic                              error_q, error_d;

  logic [AddrWidth-1:0] off;
  logic [IdxW-1:0]      idx;
  logic [2:0]           reg_sel;
  logic                 dec_err;
  logic [DataWidth-1:0] rd_val;
  logic [DataWidth-1:0] wmask;
  logic                 acc_wr;
  logic                 set_bit0;

  // An address below the base wraps to a huge offset, so the single range
  // compare also catches underflow. Inside the range idx is always < NumMbox.
  always_comb begin
    off     = req_addr_i - MboxBase;
    idx     = off[IdxW+4:5];
    reg_sel = off[4:2];
    dec_err = (off >= WinSize) || (reg_sel > 3'd5);
  end

  always_comb begin
    wmask = {{8{req_wstrb_i[3]}}, {8{req_wstrb_i[2]}},
             {8{req_wstrb_i[1]}}, {8{req_wstrb_i[0]}}};
    set_bit0 = req_wstrb_i[0] & req_wdata_i[0];
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumMbox; i++) begin
      if (idx == IdxW'(i)) begin
        case (reg_sel)
          3'd0:    rd_val = data0_q[i];
          3'd1:    rd_val = data1_q[i];
          3'd2:    rd_val = {{(DataWidth-1){1'b0}}, pend_q[i]};
          3'd4:    rd_val = {{(DataWidth-2){1'b0}}, snd_en_q[i], rcv_en_q[i]};
          3'd5:    rd_val = {{(DataWidth-2){1'b0}}, ovf_q[i], ackp_q[i]};
          default: rd_val = '0;
        endcase
      end
    end
    if (dec_err) rd_val = '0;
  end

  assign acc_wr = (state_q == IDLE) && req_valid_i && req_write_i && !dec_err;

  always_comb begin
    data0_d  = data0_q;
    data1_d  = data1_q;
    pend_d   = pend_q;
    ackp_d   = ackp_q;
    ovf_d    = ovf_q;
    rcv_en_d = rcv_en_q;
    snd_en_d = snd_en_q;
    for (int i = 0; i < NumMbox; i++) begin
      if (acc_wr && (idx == IdxW'(i))) begin
        case (reg_sel)
          3'd0: data0_d[i] = (data0_q[i] & ~wmask) | (req_wdata_i & wmask);
          3'd1: data1_d[i] = (data1_q[i] & ~wmask) | (req_wdata_i & wmask);
          3'd2: begin
            if (set_bit0) begin
              if (pend_q[i]) ovf_d[i] = 1'b1;
              pend_d[i] = 1'b1;
            end
          end
          3'd3: begin
            if (set_bit0) begin
              pend_d[i] = 1'b0;
              ackp_d[i] = 1'b1;
            end
          end
          3'd4: begin
            if (req_wstrb_i[0]) begin
              rcv_en_d[i] = req_wdata_i[0];
              snd_en_d[i] = req_wdata_i[1];
            end
          end
          3'd5: begin
            if (req_wstrb_i[0]) begin
              if (req_wdata_i[0]) ackp_d[i] = 1'b0;
              if (req_wdata_i[1]) ovf_d[i]  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rdata_d = rd_val;
          error_d = dec_err;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      data0_q  <= '0;
      data1_q  <= '0;
      pend_q   <= '0;
      ackp_q   <= '0;
      ovf_q    <= '0;
      rcv_en_q <= '0;
      snd_en_q <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      pend_q   <= pend_d;
      ackp_q   <= ackp_d;
      ovf_q    <= ovf_d;
      rcv_en_q <= rcv_en_d;
      snd_en_q <= snd_en_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  assign rsp_ready_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;
  assign rcv_irq_o   = pend_q & rcv_en_q;
  assign snd_irq_o   = ackp_q & snd_en_q;

endmodule

// File: tb/tb_carfield_mbox_responder.sv
module tb_carfield_mbox_responder;

  localparam int          NMB  = 4;
  localparam logic [47:0] BASE = 48'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [47:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [NMB-1:0] rcv_irq, snd_irq;

  int checks = 0;
  int failures = 0;

  carfield_mbox_responder #(.NumMbox(NMB)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_ready_o(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .rcv_irq_o(rcv_irq), .snd_irq_o(snd_irq)
  );

  always #5 clk = ~clk;

  // reference model: mailbox contents as plain per-mailbox variables
  logic [31:0] m_d0 [NMB];
  logic [31:0] m_d1 [NMB];
  bit m_pend [NMB], m_ackp [NMB], m_ovf [NMB], m_ren [NMB], m_sen [NMB];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NMB; i++) begin
      m_d0[i] = '0; m_d1[i] = '0;
      m_pend[i] = 0; m_ackp[i] = 0; m_ovf[i] = 0; m_ren[i] = 0; m_sen[i] = 0;
    end
  endtask

  function automatic logic [NMB-1:0] exp_rcv();
    logic [NMB-1:0] v;
    for (int i = 0; i < NMB; i++) v[i] = m_pend[i] & m_ren[i];
    return v;
  endfunction

  function automatic logic [NMB-1:0] exp_snd();
    logic [NMB-1:0] v;
    for (int i = 0; i < NMB; i++) v[i] = m_ackp[i] & m_sen[i];
    return v;
  endfunction

  task automatic model(input bit w, input logic [47:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd, output bit er);
    logic [47:0] off;
    int mb, r;
    logic [31:0] m;
    off = a - BASE;
    er  = (off >= 48'(NMB * 32)) || (off[4:2] > 3'd5);
    rd  = '0;
    if (er) return;
    mb = int'(off[47:5]);
    r  = int'(off[4:2]);
    case (r)
      0: rd = m_d0[mb];
      1: rd = m_d1[mb];
      2: rd = {31'b0, m_pend[mb]};
      4: rd = {30'b0, m_sen[mb], m_ren[mb]};
      5: rd = {30'b0, m_ovf[mb], m_ackp[mb]};
      default: rd = '0;
    endcase
    if (!w) return;
    m = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
    case (r)
      0: m_d0[mb] = (m_d0[mb] & ~m) | (wd & m);
      1: m_d1[mb] = (m_d1[mb] & ~m) | (wd & m);
      2: if (ws[0] && wd[0]) begin
           if (m_pend[mb]) m_ovf[mb] = 1;
           m_pend[mb] = 1;
         end
      3: if (ws[0] && wd[0]) begin m_pend[mb] = 0; m_ackp[mb] = 1; end
      4: if (ws[0]) begin m_ren[mb] = wd[0]; m_sen[mb] = wd[1]; end
      5: if (ws[0]) begin
           if (wd[0]) m_ackp[mb] = 0;
           if (wd[1]) m_ovf[mb] = 0;
         end
      default: ;
    endcase
  endtask

  task automatic access(input bit w, input logic [47:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit exp_er;
    int cyc;
    model(w, a, wd, ws, exp_rd, exp_er);
    @(negedge clk);
    chk("ready_idle", rsp_ready, 1'b0);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = ws;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!rsp_ready && cyc < 4);
    req_valid = 1'b0;
    chk("latency", 64'(cyc), 64'd1);
    chk("ready", rsp_ready, 1'b1);
    if (!w || exp_er) chk("rdata", rsp_rdata, exp_rd);
    chk("error", rsp_error, exp_er);
    chk("rcv_irq", rcv_irq, exp_rcv());
    chk("snd_irq", snd_irq, exp_snd());
    rd = rsp_rdata;
    @(posedge clk); #1;
    chk("ready_pulse", rsp_ready, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [47:0] a;
    logic [3:0]  ws;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", rsp_ready, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_error", rsp_error, 1'b0);
    chk("rst_irqs", {rcv_irq, snd_irq}, '0);

    access(0, 48'h4000_0008, '0, 4'h0, rd);
    chk("doorbell_reset", rd, 32'h0);

    access(1, 48'h4000_0000, 32'hDEAD_BEEF, 4'b0011, rd);
    access(0, 48'h4000_0000, '0, 4'h0, rd);
    chk("data0_strb", rd, 32'h0000_BEEF);

    access(1, 48'h4000_0030, 32'h3, 4'hF, rd);
    access(1, 48'h4000_0028, 32'h1, 4'hF, rd);
    chk("rcv_irq_mb1", rcv_irq, 4'b0010);
    access(1, 48'h4000_002C, 32'h1, 4'hF, rd);
    chk("rcv_after_ack", rcv_irq, 4'b0000);
    chk("snd_after_ack", snd_irq, 4'b0010);
    access(1, 48'h4000_0034, 32'h1, 4'hF, rd);
    chk("snd_after_w1c", snd_irq, 4'b0000);

    access(1, 48'h4000_0048, 32'h1, 4'h1, rd);
    access(1, 48'h4000_0048, 32'h1, 4'h1, rd);
    access(1, 48'h4000_004C, 32'h1, 4'h1, rd);
    access(1, 48'h4000_0054, 32'h1, 4'h1, rd);
    access(0, 48'h4000_0054, '0, 4'h0, rd);
    chk("ackstat_ovf", rd, 32'h2);
    access(1, 48'h4000_0054, 32'h2, 4'h1, rd);
    access(0, 48'h4000_0054, '0, 4'h0, rd);
    chk("ackstat_clr", rd, 32'h0);

    access(1, 48'h4000_0080, 32'h1234_5678, 4'hF, rd);
    chk("err_idx_rdata", rd, 32'h0);
    access(1, 48'h4000_0018, 32'h1234_5678, 4'hF, rd);
    access(0, 48'h4000_001C, '0, 4'h0, rd);
    access(0, 48'h3FFF_FFFC, '0, 4'h0, rd);
    access(0, 48'h4000_0000, '0, 4'h0, rd);
    chk("data0_kept", rd, 32'h0000_BEEF);

    access(1, 48'h4000_0010, 32'h1, 4'hF, rd);
    access(1, 48'h4000_0008, 32'h1, 4'hF, rd);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 48'h4000_0008; req_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("pre_rst_ready", rsp_ready, 1'b1);
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_resp_ready", rsp_ready, 1'b0);
    chk("rst_resp_irq", rcv_irq, 4'b0000);
    rst = 1'b0;
    model_reset();
    access(0, 48'h4000_0008, '0, 4'h0, rd);
    chk("pend_after_rst", rd, 32'h0);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: a = BASE + 48'($urandom_range(NMB * 32, 32'h3000 - 4));
        1: a = BASE - 48'($urandom_range(1, 64));
        2: a = BASE + 48'($urandom_range(0, NMB - 1) * 32 + $urandom_range(24, 31));
        default: a = BASE + 48'($urandom_range(0, NMB - 1) * 32 + $urandom_range(0, 5) * 4
                                + $urandom_range(0, 3));
      endcase
      ws = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      access(1'($urandom), a, $urandom, ws, rd);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    for (int i = 0; i < NMB; i++) begin
      access(0, BASE + 48'(i * 32), '0, 4'h0, rd);
      access(0, BASE + 48'(i * 32 + 4), '0, 4'h0, rd);
      access(0, BASE + 48'(i * 32 + 20), '0, 4'h0, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
